// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Purpose  : Multi-cycle instruction sequencer for the 9-bit CPU. Registers
//            each fetched instruction, classifies it, and stalls fetch for
//            loads/stores. It sequences start/run/halt, holds a done flag,
//            and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
  parameter int MEM_LAT       = 2,    // cycles a memory access is held, 1..15
  parameter int CNT_W         = 16,   // retire counter width
  parameter bit HALT_ON_UNDEF = 1'b1  // 1: undefined func codes halt
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic             instr_valid,
  output logic             fetch_en,
  output logic [8:0]       instr_q,
  output logic             ex_valid,
  output logic             load_en,
  output logic             stor_en,
  output logic             mem_sel,
  output logic             alu_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_MEM  = 2'd2;
  localparam logic [1:0] C_DONE = 2'd3;

  // The MEM countdown runs from MEM_LAT-1 to 0, so MEM lasts MEM_LAT cycles.
  localparam logic [3:0] C_MEM_LOAD = 4'(MEM_LAT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_start_q;
  logic [3:0]       r_mem_cnt;
  logic [8:0]       r_instr_q;
  logic             r_ex_valid;
  logic             r_is_load;
  logic             r_is_store;
  logic             r_is_alu;
  logic             r_is_halt;
  logic [CNT_W-1:0] r_retire_cnt;

  logic w_start_edge;
  logic w_take;
  logic w_dec_load;
  logic w_dec_store;
  logic w_dec_alu;
  logic w_dec_halt;
  logic w_mem_last;
  logic w_retire;

  // Decode the incoming word; only func codes 0-3 and 12-13 of 5'b11111 are defined.
  assign w_dec_load  = (instr[8:4] == 5'b10000);
  assign w_dec_store = (instr[8:4] == 5'b10001);
  assign w_dec_alu   = (instr[8:5] == 4'b1101);
  assign w_dec_halt  = HALT_ON_UNDEF && (instr[8:4] == 5'b11111) &&
                       !(instr[3:0] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd12, 4'd13});

  // A restart takes precedence over sampling the instruction presented alongside it.
  assign w_start_edge = start & ~r_start_q;
  assign w_take       = (r_state == C_RUN) & instr_valid & ~w_start_edge;
  assign w_mem_last   = (r_state == C_MEM) & (r_mem_cnt == 4'd0);

  // Loads/stores retire on their last MEM cycle; everything else on its ex_valid cycle.
  assign w_retire = (r_ex_valid & ~r_is_load & ~r_is_store) | w_mem_last;

  // Next-state selection; a start edge restarts into RUN from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: if (w_start_edge) w_state_nxt = C_RUN;
      C_RUN: begin
        if (w_start_edge)                     w_state_nxt = C_RUN;
        else if (w_take && (w_dec_load || w_dec_store)) w_state_nxt = C_MEM;
        else if (w_take && w_dec_halt)        w_state_nxt = C_DONE;
      end
      C_MEM: begin
        if (w_start_edge || (r_mem_cnt == 4'd0)) w_state_nxt = C_RUN;
      end
      C_DONE: if (w_start_edge) w_state_nxt = C_RUN;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  // State, start-edge history and memory latency countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= C_IDLE;
      r_start_q <= 1'b0;
      r_mem_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      if (w_take && (w_dec_load || w_dec_store))
        r_mem_cnt <= C_MEM_LOAD;
      else if ((r_state == C_MEM) && (r_mem_cnt != 4'd0))
        r_mem_cnt <= r_mem_cnt - 4'd1;
    end
  end

  // Instruction register, its class flags and the one-cycle execute strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_q  <= 9'd0;
      r_ex_valid <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_is_alu   <= 1'b0;
      r_is_halt  <= 1'b0;
    end else begin
      r_ex_valid <= w_take;
      if (w_take) begin
        r_instr_q  <= instr;
        r_is_load  <= w_dec_load;
        r_is_store <= w_dec_store;
        r_is_alu   <= w_dec_alu;
        r_is_halt  <= w_dec_halt;
      end
    end
  end

  // Retired-instruction counter, cleared by every start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_retire_cnt <= '0;
    else if (w_start_edge)
      r_retire_cnt <= '0;
    else if (w_retire)
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
  end

  // Memory strobes decode straight from state so an async reset drops them at once.
  assign fetch_en   = (r_state == C_RUN);
  assign busy       = (r_state == C_RUN) | (r_state == C_MEM);
  assign done       = (r_state == C_DONE);
  assign load_en    = (r_state == C_MEM) & r_is_load;
  assign stor_en    = (r_state == C_MEM) & r_is_store;
  assign mem_sel    = (r_state == C_MEM) & r_instr_q[3];
  assign alu_en     = r_ex_valid & r_is_alu;
  assign ex_valid   = r_ex_valid;
  assign instr_q    = r_instr_q;
  assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle successor to the combinational instruction decoder of the 9-bit CPU.
- Registers each fetched 9-bit instruction and classifies it.
- Stalls fetch for a parametrised memory latency on loads and stores, and sequences start / run / halt with a held done flag.
- Counts retired instructions.
- Sits between instruction fetch (drives fetch_en) and the datapath/data memory (drives ex_valid, load_en, stor_en, mem_sel, alu_en, instr_q).

Parameters:
MEM_LAT, 2, cycles load_en/stor_en held per memory access; legal 1..15
CNT_W, 16, width of retire counter
HALT_ON_UNDEF, 1, 1 = undefined func codes halt; 0 = treat as nop

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge (registered compare) begins/restarts a program
instr  in  9  fetched instruction, sampled when instr_valid & fetch_en
instr_valid  in  1  instr is valid this cycle
fetch_en  out  1  fetch may advance PC / present next instruction
instr_q  out  9  registered instruction under execution
ex_valid  out  1  one-cycle strobe: instr_q executes this cycle
load_en  out  1  memory read active (held MEM_LAT cycles)
stor_en  out  1  memory write active (held MEM_LAT cycles)
mem_sel  out  1  instr_q[3] captured for load/store
alu_en  out  1  instr_q is ALU math class, qualified by ex_valid
busy  out  1  state is RUN or MEM
done  out  1  halted; held until next start edge
retire_cnt  out  CNT_W  instructions retired since last start

Behaviour:
- Decode on the 9-bit word:
  - LOAD: [8:4]=5'b10000.
  - STORE: [8:4]=5'b10001.
  - ALU: [8:5]=4'b1101.
  - HALT: [8:4]=5'b11111 with [3:0] not in {0,1,2,3,12,13}, when HALT_ON_UNDEF=1.
  - Everything else is SIMPLE.
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including instr_q, retire_cnt, done and the start edge register.
- States and transitions:
  - IDLE: fetch_en=0. Start edge -> RUN; retire_cnt cleared to 0.
  - RUN: fetch_en=1. When instr_valid, instr is latched into instr_q and ex_valid pulses the next cycle (latency 1).
    - Latched LOAD/STORE -> MEM.
    - Latched HALT -> DONE.
    - Otherwise stay in RUN.
  - MEM: entered with ex_valid=1 on the first cycle.
    - load_en or stor_en=1, and mem_sel valid, for exactly MEM_LAT cycles; fetch_en=0.
    - A 4-bit down-counter is loaded with MEM_LAT-1; at 0 -> RUN.
  - DONE: done=1, fetch_en=0, busy=0. Start edge -> RUN, retire_cnt cleared, done cleared.
- Retire counting:
  - retire_cnt increments on the ex_valid cycle of SIMPLE/ALU instructions.
  - For LOAD/STORE it increments on the last MEM cycle.
  - For HALT it increments on entry to DONE.
  - The counter wraps modulo 2^CNT_W.
- alu_en = ex_valid & ALU class. mem_sel = 0 outside MEM.
- Back-to-back: in RUN, a new instruction may be latched in the same cycle the previous one's ex_valid fires, giving 1 instruction/cycle for SIMPLE/ALU. The fetch_en drop for MEM takes effect on the cycle LOAD/STORE is latched, so the instruction after LOAD/STORE is not sampled until MEM exits.
- instr_valid=0 in RUN: no latch, no ex_valid; the machine stays in RUN.
- Start edge while busy (RUN/MEM): restart. Abort any memory access (load_en/stor_en drop next cycle), enter RUN, clear retire_cnt; no ex_valid for the aborted instruction.
- rst_n asserted mid-MEM: load_en/stor_en drop immediately (asynchronous).
- start held high continuously produces exactly one edge.

Test Plan:
- Reset, then start edge, then instrs 0x005, 0x1A3 (ALU), 0x000 -> ex_valid on 3 consecutive cycles; alu_en only on the 2nd; retire_cnt=3; fetch_en stays 1.
- Start, then LOAD 0x10A (mem_sel=1) with MEM_LAT=2 -> load_en=1 for exactly 2 cycles; fetch_en=0 over that span; mem_sel=1; retire_cnt increments on the 2nd cycle; RUN resumes.
- STORE 0x113 with MEM_LAT=1 and MEM_LAT=15 -> stor_en width 1 and 15 respectively; mem_sel=0.
- Instr 0x1F7 -> done=1 held across 20 idle cycles, busy=0, retire_cnt +1. Start edge -> done=0, retire_cnt=0.
- Instrs 0x1F0 and 0x1FC -> not halt, treated as SIMPLE. With HALT_ON_UNDEF=0, 0x1F7 also does not halt.
- Start edge during a MEM cycle -> load_en drops next cycle, retire_cnt=0, state RUN. rst_n pulse mid-MEM -> all outputs 0 asynchronously.
